seq_detect_prog: RTL

//  Runtime-programmable serial pattern detector, successor to the fixed 6-state detector.

---
 rtl/seq_detect_prog.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
// Runtime-programmable serial pattern detector. It watches a qualified 1-bit
// stream and pulses flag when the last len valid bits equal the programmed
// pattern. It supports overlapping and non-overlapping detection and keeps a
// saturating count of matches.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   clr                    sync clear of history, flag, match_cnt, cnt_ovf
//   cfg_we                 load cfg_pattern / cfg_len / cfg_mode this cycle
//   cfg_pattern [MAX_LEN]  bit[len-1] = first bit received, bit[0] = last
//   cfg_len     [LEN_W]    pattern length, legal 1..MAX_LEN
//   cfg_mode               0 = overlapping, 1 = non-overlapping
//   cfg_err                1-cycle pulse: a cfg_we with an illegal length was dropped
//   data_valid, data_in    serial bit and its qualifier
//   flag                   registered 1-cycle match pulse
//   match_cnt   [CNT_W]    saturating match count
//   cnt_ovf                sticky: a match arrived while match_cnt was all-ones
//
// Handshake: data_valid is a pure qualifier with no back-pressure. A bit is
// consumed on every rising edge where data_valid=1 and neither clr nor cfg_we
// is high. The per-cycle priority is clr > cfg_we > data_valid.
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int               MAX_LEN     = 16,
  parameter int               LEN_W       = 5,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 16'h0029,
  parameter int               RST_LEN     = 6,
  parameter logic             RST_MODE    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_mode,
  output logic               cfg_err,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_ovf
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               mode_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;
  logic [LEN_W-1:0]   fill_n;
  logic               match;
  logic               cfg_ok;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  always_comb begin
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    cand   = {hist_q[MAX_LEN-2:0], data_in};
    // fill saturates at MAX_LEN so a long stream never wraps the counter
    fill_n = (fill_q == MAX_LEN_V) ? MAX_LEN_V : fill_q + 1'b1;
    // a window only counts once enough fresh bits are held to cover it
    match  = (fill_n >= len_q) && (((cand ^ pattern_q) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      mode_q    <= RST_MODE;
      hist_q    <= '0;
      fill_q    <= '0;
      flag      <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else begin
      flag    <= 1'b0;
      cfg_err <= 1'b0;
      if (clr) begin
        hist_q    <= '0;
        fill_q    <= '0;
        match_cnt <= '0;
        cnt_ovf   <= 1'b0;
      end else if (cfg_we) begin
        if (cfg_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          mode_q    <= cfg_mode;
          hist_q    <= '0;
          fill_q    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (data_valid) begin
        hist_q <= cand;
        // non-overlap mode retires the whole matched window by emptying fill
        fill_q <= (mode_q && match) ? '0 : fill_n;
        flag   <= match;
        if (match) begin
          if (match_cnt == CNT_MAX) cnt_ovf <= 1'b1;
          else                      match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule
